// File: rtl/bn_stat_ctrl_if.sv
// Handshake, job-control and datapath-return bundle for the batch-norm statistics controller.
// The master side is the job requester / datapath, and the slave side is the controller.
interface bn_stat_ctrl_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned LW = 3
);
  logic              start;
  logic              mode;
  logic [LW-1:0]     log2_beats;
  logic              in_valid;
  logic              in_ready;
  logic              dp_select;
  logic              dp_reset;
  logic [N-1:0]      dp_mean1;
  logic [2*N-1:0]    dp_mean2;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      mean1_out;
  logic [2*N-1:0]    mean2_out;

  modport master (
    output start, mode, log2_beats, in_valid, dp_mean1, dp_mean2, out_ready,
    input  in_ready, dp_select, dp_reset, busy, out_valid, mean1_out, mean2_out
  );

  modport slave (
    input  start, mode, log2_beats, in_valid, dp_mean1, dp_mean2, out_ready,
    output in_ready, dp_select, dp_reset, busy, out_valid, mean1_out, mean2_out
  );
endinterface

// File: rtl/bn_stat_ctrl.sv
// Batch-norm statistics sequencer: clears the datapath, admits 2^L beats, and accumulates the
// per-beat means that return DP_LAT cycles later. It then presents the floored job means.
module bn_stat_ctrl #(
  parameter int unsigned N      = 16,
  parameter int unsigned MAX_L  = 4,
  parameter int unsigned LW     = 3,
  parameter int unsigned DP_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bn_stat_ctrl_if.slave      io_bus
);

  localparam int unsigned CW  = MAX_L + 1;
  localparam int unsigned N2  = 2 * N;
  localparam int unsigned A1W = N + MAX_L;
  localparam int unsigned A2W = N2 + MAX_L;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [LW-1:0]          r_l;
  logic [LW-1:0]          w_l_clamp;
  logic [CW-1:0]          r_issue_cnt;
  logic [CW-1:0]          r_cap_cnt;
  logic [CW-1:0]          w_cap_cnt_nxt;
  logic [CW-1:0]          w_beats;
  logic [DP_LAT-1:0]      r_flag;
  logic [DP_LAT-1:0]      w_flag_shift;
  logic signed [A1W-1:0]  r_acc1;
  logic signed [A1W-1:0]  w_acc1_nxt;
  logic signed [A2W-1:0]  r_acc2;
  logic signed [A2W-1:0]  w_acc2_nxt;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_last_issue;
  logic                   w_cap_done;

  logic                   r_in_ready;
  logic                   r_busy;
  logic                   r_out_valid;
  logic                   r_dp_select;
  logic                   r_dp_reset;
  logic [N-1:0]           r_mean1;
  logic [N2-1:0]          r_mean2;

  logic                   w_in_ready_nxt;
  logic                   w_busy_nxt;
  logic                   w_out_valid_nxt;
  logic                   w_dp_reset_nxt;

  assign w_l_clamp     = (io_bus.log2_beats > LW'(MAX_L)) ? LW'(MAX_L) : io_bus.log2_beats;
  assign w_beats       = CW'(1) << r_l;
  assign w_accept      = io_bus.in_valid & r_in_ready;
  assign w_capture     = r_flag[DP_LAT-1];
  assign w_last_issue  = w_accept && (r_issue_cnt == (w_beats - CW'(1)));
  assign w_cap_cnt_nxt = r_cap_cnt + CW'(w_capture);
  assign w_cap_done    = (w_cap_cnt_nxt == w_beats);

  // Sums include the capture landing this cycle, so a coincident final beat is counted
  assign w_acc1_nxt = w_capture ? (r_acc1 + A1W'($signed(io_bus.dp_mean1))) : r_acc1;
  assign w_acc2_nxt = w_capture ? (r_acc2 + A2W'($signed(io_bus.dp_mean2))) : r_acc2;

  generate
    if (DP_LAT == 1) begin : g_lat1
      assign w_flag_shift = w_accept;
    end else begin : g_latn
      assign w_flag_shift = {r_flag[DP_LAT-2:0], w_accept};
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and look-ahead output decode (outputs are registered from the next state)
  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = 1'b0;
    w_busy_nxt      = 1'b1;
    w_out_valid_nxt = 1'b0;
    w_dp_reset_nxt  = 1'b1;

    unique case (r_state)
      S_IDLE:  if (io_bus.start)     w_state_nxt = S_CLEAR;
      S_CLEAR:                       w_state_nxt = S_RUN;
      S_RUN:   if (w_last_issue)     w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_cap_done)       w_state_nxt = S_DONE;
      S_DONE:  if (io_bus.out_ready) w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase

    unique case (w_state_nxt)
      S_IDLE:  w_busy_nxt      = 1'b0;
      S_CLEAR: w_dp_reset_nxt  = 1'b0;
      S_RUN:   w_in_ready_nxt  = 1'b1;
      S_DONE:  w_out_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  // Job latch, counters, capture delay line, accumulators and result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_l         <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_flag      <= '0;
      r_acc1      <= '0;
      r_acc2      <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_dp_select <= 1'b0;
      r_dp_reset  <= 1'b0;
      r_mean1     <= '0;
      r_mean2     <= '0;
    end else begin
      r_flag      <= w_flag_shift;
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_dp_reset  <= w_dp_reset_nxt;

      if ((r_state == S_IDLE) && io_bus.start) begin
        r_l         <= w_l_clamp;
        r_dp_select <= io_bus.mode;
      end

      if (r_state == S_CLEAR) begin
        r_issue_cnt <= '0;
        r_cap_cnt   <= '0;
        r_acc1      <= '0;
        r_acc2      <= '0;
      end else begin
        r_cap_cnt <= w_cap_cnt_nxt;
        r_acc1    <= w_acc1_nxt;
        r_acc2    <= w_acc2_nxt;
        if (w_accept) begin
          r_issue_cnt <= r_issue_cnt + CW'(1);
        end
      end

      // Arithmetic shift of the signed sum gives the floor of the average
      if ((r_state == S_DRAIN) && w_cap_done) begin
        r_mean1 <= N'(w_acc1_nxt >>> r_l);
        r_mean2 <= N2'(w_acc2_nxt >>> r_l);
      end
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.busy      = r_busy;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.dp_select = r_dp_select;
  assign io_bus.dp_reset  = r_dp_reset;
  assign io_bus.mean1_out = r_mean1;
  assign io_bus.mean2_out = r_mean2;

endmodule

// File: tb/tb_bn_stat_ctrl.sv
// Testbench for bn_stat_ctrl. A stub datapath returns per-beat values one cycle after each
// acceptance, and expected job means are floored averages computed from those values.
module tb_bn_stat_ctrl;

  localparam int unsigned N      = 16;
  localparam int unsigned N2     = 2 * N;
  localparam int unsigned MAX_L  = 4;
  localparam int unsigned LW     = 3;
  localparam int unsigned DP_LAT = 1;
  localparam int          MAXB   = 1 << MAX_L;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  int acc_cnt;
  int job_base = 0;
  int idx;

  logic [N-1:0]  v1 [MAXB];
  logic [N2-1:0] v2 [MAXB];

  bn_stat_ctrl_if #(.N(N), .LW(LW)) bus ();

  bn_stat_ctrl #(.N(N), .MAX_L(MAX_L), .LW(LW), .DP_LAT(DP_LAT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub datapath: per-beat result valid the cycle after acceptance, noise otherwise
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt      <= 0;
      bus.dp_mean1 <= '0;
      bus.dp_mean2 <= '0;
    end else if (bus.in_valid && bus.in_ready) begin
      idx = acc_cnt - job_base;
      if (idx >= 0 && idx < MAXB) begin
        bus.dp_mean1 <= v1[idx];
        bus.dp_mean2 <= v2[idx];
      end else begin
        bus.dp_mean1 <= N'($urandom);
        bus.dp_mean2 <= $urandom;
      end
      acc_cnt <= acc_cnt + 1;
    end else begin
      bus.dp_mean1 <= N'($urandom);
      bus.dp_mean2 <= $urandom;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint s, input int l);
    longint d;
    longint q;
    d = longint'(1) << l;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic md, input logic [LW-1:0] lg, input int stall_at,
                         input int stall_len, input bit rnd, input int hold);
    int           l;
    int           beats;
    int           edges;
    int           waitc;
    int           extra;
    bit           stalled;
    longint       s1;
    longint       s2;
    logic [N-1:0] e1;
    logic [N2-1:0] e2;

    l     = (int'(lg) > int'(MAX_L)) ? int'(MAX_L) : int'(lg);
    beats = 1 << l;
    s1 = 0;
    s2 = 0;
    for (int b = 0; b < beats; b++) begin
      s1 += longint'($signed(v1[b]));
      s2 += longint'($signed(v2[b]));
    end
    e1 = N'(floor_div(s1, l));
    e2 = N2'(floor_div(s2, l));
    stalled = (stall_len > 0) || rnd;

    job_base       = acc_cnt;
    bus.start      = 1'b1;
    bus.mode       = md;
    bus.log2_beats = lg;
    tick();
    bus.start      = 1'b0;
    bus.mode       = ~md;
    bus.log2_beats = LW'($urandom);
    chk("clear_dp_reset", bus.dp_reset, 1'b0);
    chk("clear_select", bus.dp_select, md);
    chk("clear_busy", bus.busy, 1'b1);
    chk("clear_in_ready", bus.in_ready, 1'b0);

    tick();
    edges = 1;
    chk("run_dp_reset", bus.dp_reset, 1'b1);
    chk("run_in_ready", bus.in_ready, 1'b1);

    for (int b = 0; b < beats; b++) begin
      extra = 0;
      if (b == stall_at) extra = stall_len;
      if (rnd && $urandom_range(0, 2) == 0) extra = extra + $urandom_range(1, 3);
      if (extra > 0) begin
        bus.in_valid = 1'b0;
        repeat (extra) tick();
        edges += extra;
        chk("stall_count", 64'(acc_cnt - job_base), 64'(b));
        chk("stall_in_ready", bus.in_ready, 1'b1);
      end
      bus.in_valid = 1'b1;
      tick();
      edges++;
      chk("accept_count", 64'(acc_cnt - job_base), 64'(b + 1));
    end
    chk("in_ready_drop", bus.in_ready, 1'b0);

    waitc = 0;
    while (!bus.out_valid && waitc < 200) begin
      tick();
      waitc++;
      edges++;
    end
    chk("out_valid_seen", bus.out_valid, 1'b1);
    if (!stalled) chk("latency", 64'(edges), 64'(1 + beats + DP_LAT));
    chk("mean1", bus.mean1_out, e1);
    chk("mean2", bus.mean2_out, e2);
    chk("done_select", bus.dp_select, md);
    chk("done_busy", bus.busy, 1'b1);

    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_out_valid", bus.out_valid, 1'b1);
      chk("hold_mean1", bus.mean1_out, e1);
      chk("hold_mean2", bus.mean2_out, e2);
    end

    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    chk("out_valid_drop", bus.out_valid, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_mean1", bus.mean1_out, e1);
    chk("idle_mean2", bus.mean2_out, e2);
    chk("idle_select", bus.dp_select, md);
    tick();
    chk("no_restart", bus.busy, 1'b0);
    chk("accept_total", 64'(acc_cnt - job_base), 64'(beats));
  endtask

  task automatic fill_random();
    for (int b = 0; b < MAXB; b++) begin
      v1[b] = N'($urandom);
      v2[b] = $urandom;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.log2_beats = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    fill_random();

    #3;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_select", bus.dp_select, 1'b0);
    chk("rst_dp_reset", bus.dp_reset, 1'b0);
    chk("rst_mean1", bus.mean1_out, '0);
    chk("rst_mean2", bus.mean2_out, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_dp_reset", bus.dp_reset, 1'b1);
    chk("idle_in_ready", bus.in_ready, 1'b0);

    // Forward, L=1: means 4,3 and 25,16
    v1[0] = N'(4);   v1[1] = N'(3);
    v2[0] = N2'(25); v2[1] = N2'(16);
    run_job(1'b0, LW'(1), -1, 0, 1'b0, 0);

    // Backward, L=1 with negative values and a short output stall
    v1[0] = N'(-3);  v1[1] = N'(-4);
    v2[0] = N2'(-10); v2[1] = N2'(2);
    run_job(1'b1, LW'(1), -1, 0, 1'b0, 2);

    // L=2 with a 3-cycle in_valid gap before the third beat
    for (int b = 0; b < 4; b++) begin
      v1[b] = N'(b + 1);
      v2[b] = N2'(b * 7);
    end
    run_job(1'b0, LW'(2), 2, 3, 1'b0, 0);

    // Oversized length clamps to 16 beats
    fill_random();
    run_job(1'b1, LW'(7), -1, 0, 1'b0, 0);

    // Consumer stalls 5 cycles in DONE
    fill_random();
    run_job(1'b0, LW'(3), -1, 0, 1'b0, 5);

    // Single-beat job passes the value through unshifted
    v1[0] = N'(-12345);
    v2[0] = N2'(-7);
    run_job(1'b1, LW'(0), -1, 0, 1'b0, 0);

    // Abort mid-RUN after one accepted beat
    fill_random();
    bus.start      = 1'b1;
    bus.mode       = 1'b1;
    bus.log2_beats = LW'(2);
    tick();
    bus.start = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_in_ready", bus.in_ready, 1'b0);
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_select", bus.dp_select, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    fill_random();
    run_job(1'b0, LW'(2), -1, 0, 1'b0, 1);

    // Randomized jobs with random stalls and consumer back-pressure
    for (int j = 0; j < 12; j++) begin
      fill_random();
      run_job(1'($urandom), LW'($urandom_range(0, 7)), -1, 0, 1'b1, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
